// File: rtl/mac_tile_mp_pkg.sv
// -----------------------------------------------------------------------------
// mac_tile_mp_pkg
//   Shared encodings for the multi-precision, multi-dataflow MAC tile.
//   - mode_e     : dataflow selection (WS4 / WS2 / OS; 2'b11 behaves as WS4)
//   - INST_*     : bit positions inside the 3-bit instruction word
// -----------------------------------------------------------------------------
package mac_tile_mp_pkg;

   typedef enum logic [1:0] {
      MODE_WS4  = 2'b00,
      MODE_WS2  = 2'b01,
      MODE_OS   = 2'b10,
      MODE_RSVD = 2'b11
   } mode_e;

   localparam int INST_LOAD = 0;
   localparam int INST_EXEC = 1;
   localparam int INST_CLR  = 2;   // clear in WS, drain in OS
   localparam int INST_W    = 3;

endpackage

// File: rtl/mac_tile_mp_mul_lane.sv
// -----------------------------------------------------------------------------
// mac_mul_lane
//   Combinational unsigned x signed multiplier.
//   Ports:
//     i_a  [A_W-1:0] : unsigned multiplicand (activation)
//     i_b  [B_W-1:0] : two's-complement multiplier (weight)
//     o_p  [P_W-1:0] : product, sign-extended to P_W bits (P_W > A_W+B_W)
// -----------------------------------------------------------------------------
module mac_mul_lane #(
   parameter int A_W = 4,
   parameter int B_W = 4,
   parameter int P_W = 16
) (
   input  logic [A_W-1:0] i_a,
   input  logic [B_W-1:0] i_b,
   output logic [P_W-1:0] o_p
);

   localparam int PR_W = A_W + B_W + 1;

   // Both operands widened to the exact product width so the signed multiply
   // is self-contained: a is zero-extended, b is sign-extended.
   logic signed [PR_W-1:0] w_a_ext;
   logic signed [PR_W-1:0] w_b_ext;
   logic signed [PR_W-1:0] w_prod;

   assign w_a_ext = {{(B_W+1){1'b0}}, i_a};
   assign w_b_ext = {{(A_W+1){i_b[B_W-1]}}, i_b};
   assign w_prod  = w_a_ext * w_b_ext;

   assign o_p = {{(P_W-PR_W){w_prod[PR_W-1]}}, w_prod};

endmodule

// File: rtl/mac_tile_mp.sv
// -----------------------------------------------------------------------------
// mac_tile_mp
//   Processing element for the systolic array supporting three dataflows:
//   4-bit weight-stationary (WS4), dual-lane 2-bit-activation weight-stationary
//   (WS2) and output-stationary (OS) with a column shift-drain.
//   Ports:
//     clk, reset          : clock, synchronous active-high reset
//     mode   [1:0]        : 00 WS4, 01 WS2, 10 OS, 11 as WS4
//     in_w   [bw-1:0]     : activation / weight word from the west
//     inst_w [2:0]        : {clear|drain, execute, load} from the west
//     out_e  [bw-1:0]     : registered activation to the east
//     inst_e [2:0]        : registered instruction to the east
//     in_n   [psum_bw-1:0]: psum (WS), weight in low bits (OS exec),
//                           upper accumulator (OS drain)
//     out_s  [psum_bw-1:0]: psum (WS), forwarded weight or accumulator (OS)
// -----------------------------------------------------------------------------
module mac_tile_mp
   import mac_tile_mp_pkg::*;
#(
   parameter int bw      = 4,
   parameter int psum_bw = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [1:0]         mode,
   input  logic [bw-1:0]      in_w,
   input  logic [2:0]         inst_w,
   output logic [bw-1:0]      out_e,
   output logic [2:0]         inst_e,
   input  logic [psum_bw-1:0] in_n,
   output logic [psum_bw-1:0] out_s
);

   localparam int HB = bw / 2;

   if ((bw % 2) != 0) begin : g_bad_bw
      $error("mac_tile_mp: bw must be even");
   end
   if (psum_bw < 2*bw + 2) begin : g_bad_psum
      $error("mac_tile_mp: psum_bw must be at least 2*bw+2");
   end

   logic [bw-1:0]      r_a;
   logic [bw-1:0]      r_w0;
   logic [bw-1:0]      r_w1;
   logic [bw-1:0]      r_wn;
   logic [psum_bw-1:0] r_acc;
   logic [2:0]         r_inst;
   logic               r_full;
   logic               r_cnt;

   logic               w_os;
   logic               w_ws2;
   logic               w_ws;
   logic [bw-1:0]      w_mul_a;
   logic [bw-1:0]      w_mul_b;
   logic [psum_bw-1:0] w_p_full;
   logic [psum_bw-1:0] w_p_lo;
   logic [psum_bw-1:0] w_p_hi;

   assign w_os  = (mode == MODE_OS);
   assign w_ws2 = (mode == MODE_WS2);
   assign w_ws  = !w_os;             // WS4, WS2 and the reserved code

   // The full-width lane is shared: WS4 multiplies the registered operands,
   // OS multiplies the live activation by the weight arriving from the north.
   assign w_mul_a = w_os ? in_w          : r_a;
   assign w_mul_b = w_os ? in_n[bw-1:0]  : r_w0;

   mac_mul_lane #(.A_W(bw), .B_W(bw), .P_W(psum_bw)) u_mul_full (
      .i_a (w_mul_a),
      .i_b (w_mul_b),
      .o_p (w_p_full)
   );

   mac_mul_lane #(.A_W(HB), .B_W(bw), .P_W(psum_bw)) u_mul_lo (
      .i_a (r_a[HB-1:0]),
      .i_b (r_w0),
      .o_p (w_p_lo)
   );

   mac_mul_lane #(.A_W(HB), .B_W(bw), .P_W(psum_bw)) u_mul_hi (
      .i_a (r_a[bw-1:HB]),
      .i_b (r_w1),
      .o_p (w_p_hi)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_a    <= '0;
         r_w0   <= '0;
         r_w1   <= '0;
         r_wn   <= '0;
         r_acc  <= '0;
         r_inst <= '0;
         r_full <= 1'b0;
         r_cnt  <= 1'b0;
      end else begin
         if (inst_w != 3'b000)
            r_a <= in_w;

         r_inst[INST_EXEC] <= inst_w[INST_EXEC];
         r_inst[INST_CLR]  <= inst_w[INST_CLR];
         // A load word passes east only once this tile is already full; a
         // WS clear in the same cycle swallows the word entirely.
         r_inst[INST_LOAD] <= inst_w[INST_LOAD] & r_full
                              & ~(w_ws & inst_w[INST_CLR]);

         if (w_ws) begin
            if (inst_w[INST_CLR]) begin
               // Weights stay in place; only the fill state is re-armed.
               r_full <= 1'b0;
               r_cnt  <= 1'b0;
            end else if (inst_w[INST_LOAD] && !r_full) begin
               if (w_ws2) begin
                  if (!r_cnt) begin
                     r_w0  <= in_w;
                     r_cnt <= 1'b1;
                  end else begin
                     r_w1   <= in_w;
                     r_cnt  <= 1'b0;
                     r_full <= 1'b1;
                  end
               end else begin
                  r_w0   <= in_w;
                  r_full <= 1'b1;
               end
            end
         end else begin
            // Drain shifts the upper tile's accumulator in and beats execute.
            if (inst_w[INST_CLR]) begin
               r_acc <= in_n;
            end else if (inst_w[INST_EXEC]) begin
               r_acc <= r_acc + w_p_full;
               r_wn  <= in_n[bw-1:0];
            end
         end
      end
   end

   assign out_e  = r_a;
   assign inst_e = r_inst;

   always_comb begin
      out_s = in_n + w_p_full;
      if (w_os)
         out_s = inst_w[INST_CLR] ? r_acc : {{(psum_bw-bw){1'b0}}, r_wn};
      else if (w_ws2)
         out_s = in_n + w_p_lo + w_p_hi;
   end

endmodule

// File: tb/tb_mac_tile_mp.sv
// Directed-vector bench for mac_tile_mp (bw=4, psum_bw=16).
module tb_mac_tile_mp;

   logic        clk;
   logic        reset;
   logic [1:0]  mode;
   logic [3:0]  in_w;
   logic [2:0]  inst_w;
   logic [3:0]  out_e;
   logic [2:0]  inst_e;
   logic [15:0] in_n;
   logic [15:0] out_s;

   int n_vec = 0;
   int n_bad = 0;

   mac_tile_mp #(.bw(4), .psum_bw(16)) dut (
      .clk    (clk),
      .reset  (reset),
      .mode   (mode),
      .in_w   (in_w),
      .inst_w (inst_w),
      .out_e  (out_e),
      .inst_e (inst_e),
      .in_n   (in_n),
      .out_s  (out_s)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // advance one clock; inputs are then driven / outputs sampled 1 after the edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [2:0] inst, input logic [3:0] w, input logic [15:0] n);
      inst_w = inst;
      in_w   = w;
      in_n   = n;
   endtask

   initial begin
      reset = 1'b1; mode = 2'b00;
      drive(3'b000, 4'h0, 16'h1234);
      step(); step();
      reset = 1'b0;
      #1;
      chk("rst_out_e", 32'(out_e), 32'h0);
      chk("rst_inst_e", 32'(inst_e), 32'h0);
      chk("rst_out_s_ws", 32'(out_s), 32'h1234);
      mode = 2'b10; #1;
      chk("rst_out_s_os", 32'(out_s), 32'h0);
      mode = 2'b00;

      // WS4: load w0=3, execute a=5 with in_n=100
      drive(3'b001, 4'h3, 16'd0); step();
      chk("ws4_load_inst_e", 32'(inst_e), 32'h0);
      chk("ws4_load_out_e", 32'(out_e), 32'h3);
      drive(3'b010, 4'h5, 16'd100); step();
      chk("ws4_out_s", 32'(out_s), 32'd115);
      chk("ws4_inst_e_exec", 32'(inst_e), 32'b010);

      // wrap: w0=1, a=1, in_n=FFFF
      drive(3'b100, 4'h0, 16'd0); step();
      drive(3'b001, 4'h1, 16'd0); step();
      drive(3'b010, 4'h1, 16'hFFFF); step();
      chk("ws4_wrap", 32'(out_s), 32'h0);

      // clear+load while full: clear wins, word 7 discarded
      drive(3'b101, 4'h7, 16'd0); step();
      chk("clrld_inst_e", 32'(inst_e), 32'b100);
      chk("clrld_out_e", 32'(out_e), 32'h7);
      drive(3'b010, 4'h2, 16'd0); step();
      chk("clrld_w0_kept", 32'(out_s), 32'd2);
      drive(3'b001, 4'h6, 16'd0); step();
      chk("clrld_reload_inst_e", 32'(inst_e), 32'h0);
      drive(3'b010, 4'h3, 16'd0); step();
      chk("clrld_reload_w0", 32'(out_s), 32'd18);
      drive(3'b001, 4'h9, 16'd0); step();
      chk("ws4_fwd_inst_e", 32'(inst_e), 32'b001);
      chk("ws4_fwd_out_e", 32'(out_e), 32'h9);

      // WS2 signed: w0=-1, w1=2; a=1110 -> -2 + 6 = 4
      mode = 2'b01;
      drive(3'b100, 4'h0, 16'd0); step();
      drive(3'b001, 4'hF, 16'd0); step();
      chk("ws2_ld0_inst_e", 32'(inst_e), 32'h0);
      drive(3'b001, 4'h2, 16'd0); step();
      chk("ws2_ld1_inst_e", 32'(inst_e), 32'h0);
      drive(3'b001, 4'h5, 16'd0); step();
      chk("ws2_ld2_inst_e", 32'(inst_e), 32'b001);
      chk("ws2_ld2_out_e", 32'(out_e), 32'h5);
      drive(3'b010, 4'b1110, 16'd0); step();
      chk("ws2_out_s", 32'(out_s), 32'd4);
      in_n = 16'd1000; #1;
      chk("ws2_out_s_psum", 32'(out_s), 32'd1004);

      // reset in the middle of a WS2 load
      drive(3'b100, 4'h0, 16'd0); step();
      drive(3'b001, 4'h3, 16'd0); step();
      drive(3'b000, 4'h0, 16'd0);
      reset = 1'b1; step();
      reset = 1'b0;
      chk("rstmid_out_e", 32'(out_e), 32'h0);
      chk("rstmid_inst_e", 32'(inst_e), 32'h0);
      drive(3'b001, 4'h1, 16'd0); step();
      drive(3'b001, 4'h2, 16'd0); step();
      chk("rstmid_ld1_inst_e", 32'(inst_e), 32'h0);
      drive(3'b010, 4'b0101, 16'd0); step();
      chk("rstmid_out_s", 32'(out_s), 32'd3);

      // OS: (2,3), (4,-1), (1,7) -> acc = 9
      mode = 2'b10;
      drive(3'b010, 4'h2, 16'd3); step();
      chk("os_wfwd0", 32'(out_s), 32'd3);
      drive(3'b010, 4'h4, 16'h000F); step();
      chk("os_wfwd1", 32'(out_s), 32'h000F);
      drive(3'b010, 4'h1, 16'd7); step();
      chk("os_wfwd2", 32'(out_s), 32'd7);
      drive(3'b100, 4'h0, 16'd55); #1;
      chk("os_drain_acc", 32'(out_s), 32'd9);
      step();
      in_n = 16'd0; #1;
      chk("os_drain_shift", 32'(out_s), 32'd55);
      step();
      drive(3'b000, 4'h0, 16'd0); #1;
      chk("os_wn_hold", 32'(out_s), 32'd7);
      // drain beats execute: acc <- 5, wn unchanged
      drive(3'b110, 4'h2, 16'd5); step();
      drive(3'b000, 4'h0, 16'd0); #1;
      chk("os_drain_prio_wn", 32'(out_s), 32'd7);
      drive(3'b100, 4'h0, 16'd0); #1;
      chk("os_drain_prio_acc", 32'(out_s), 32'd5);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
